// File: rtl/riscv_pkg.sv
// Shared RISC-V immediate definitions used by both the immediate extender and the encoder.
package riscv_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immsrc_t;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -1048576;
    localparam int IMM21_MAX = 1048574;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous valid/ready FIFO. The head is read straight from registered storage,
// and out_data reads as zero whenever the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Readiness looks only at the stored count, so a pop never frees a slot in the same cycle.
    assign in_ready  = rst_n & ~clear & (count < FULL);
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~clear;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imm_encode.sv
// Scatters a signed immediate into an I/S/B/J instruction template, flags out-of-range values,
// and queues the finished words with sequential imem word addresses.
module imm_encode
    import riscv_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       base_i,
    input  logic [1:0]        immsrc_i,
    input  logic [31:0]       imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              range_err_o,
    output logic [7:0]        err_cnt_o
);

    localparam int W = 32 + ADDR_W + 1;

    logic signed [31:0] imm_s;
    logic [31:0]        instr;
    logic               range_err;
    logic [ADDR_W-1:0]  addr_cnt;
    logic [7:0]         err_cnt;
    logic               accept;
    logic [W-1:0]       head;

    assign imm_s = $signed(imm_i);

    always_comb begin
        instr     = base_i;
        range_err = 1'b0;
        case (immsrc_t'(immsrc_i))
            IMM_I: begin
                instr[31:20] = imm_i[11:0];
                range_err    = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
            end
            IMM_S: begin
                instr[31:25] = imm_i[11:5];
                instr[11:7]  = imm_i[4:0];
                range_err    = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
            end
            IMM_B: begin
                instr[31]    = imm_i[12];
                instr[30:25] = imm_i[10:5];
                instr[11:8]  = imm_i[4:1];
                instr[7]     = imm_i[11];
                range_err    = (imm_s < IMM13_MIN) || (imm_s > IMM13_MAX) || imm_i[0];
            end
            IMM_J: begin
                instr[31]    = imm_i[20];
                instr[30:21] = imm_i[10:1];
                instr[20]    = imm_i[11];
                instr[19:12] = imm_i[19:12];
                range_err    = (imm_s < IMM21_MIN) || (imm_s > IMM21_MAX) || imm_i[0];
            end
            default: begin
                instr     = base_i;
                range_err = 1'b0;
            end
        endcase
    end

    assign accept = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            addr_cnt <= '0;
            err_cnt  <= '0;
        end else if (accept) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            if (range_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .clear     (clear_i),
        .in_valid  (in_valid_i),
        .in_ready  (in_ready_o),
        .in_data   ({instr, addr_cnt, range_err}),
        .out_valid (out_valid_o),
        .out_ready (out_ready_i),
        .out_data  (head)
    );

    assign {instr_o, addr_o, range_err_o} = head;
    assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_imm_encode.sv
// Directed bench for imm_encode: field packing, range errors, backpressure, wrap,
// saturation, clear/reset mid-stream, and an extender round trip.
module tb_imm_encode;
    import riscv_pkg::*;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   base = '0;
    logic [1:0]    immsrc = '0;
    logic [31:0]   imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   instr;
    logic [AW-1:0] addr;
    logic          range_err;
    logic [7:0]    err_cnt;

    int n_vec = 0;
    int n_err = 0;

    imm_encode #(.DEPTH(2), .ADDR_W(AW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .base_i      (base),
        .immsrc_i    (immsrc),
        .imm_i       (imm),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .instr_o     (instr),
        .addr_o      (addr),
        .range_err_o (range_err),
        .err_cnt_o   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called in the low clock phase; returns at the negedge after the accepting edge.
    task automatic push_word(input logic [1:0] f, input logic [31:0] b, input logic [31:0] v);
        int waited;
        immsrc   = f;
        base     = b;
        imm      = v;
        in_valid = 1'b1;
        #1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) chk("accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    function automatic logic [31:0] extend(input logic [31:0] i, input logic [1:0] f);
        case (f)
            2'b00:   return {{20{i[31]}}, i[31:20]};
            2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
            2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] keep_mask(input logic [1:0] f);
        case (f)
            2'b00:   return 32'h000F_FFFF;
            2'b01:   return 32'h01FF_F07F;
            2'b10:   return 32'h01FF_F07F;
            default: return 32'h0000_0FFF;
        endcase
    endfunction

    logic [1:0] bnd_fmt [10] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1};
    int         bnd_imm [10] = '{2047, -2048, -2049, 4094, -4096, 4096,
                                 1048574, -1048576, 1048576, 2047};
    logic       bnd_err [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int exp_cnt;
        int exp_addr;
        int acc;
        logic [1:0]  f;
        logic [31:0] v;
        logic [31:0] b;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_range_err", {31'b0, range_err}, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Field packing
        push_word(2'd0, 32'h0000_0013, 32'hFFFF_FFFF);
        chk("i_valid", {31'b0, out_valid}, 32'd1);
        chk("i_instr", instr, 32'hFFF0_0013);
        chk("i_addr", 32'(addr), 32'd0);
        chk("i_err", {31'b0, range_err}, 32'd0);
        push_word(2'd1, 32'h0051_2023, 32'd8);
        chk("s_instr", instr, 32'h0051_2423);
        chk("s_addr", 32'(addr), 32'd1);
        push_word(2'd2, 32'h0000_0063, 32'hFFFF_FFFC);
        chk("b_instr", instr, 32'hFE00_0EE3);
        chk("b_addr", 32'(addr), 32'd2);
        push_word(2'd3, 32'h0000_006F, 32'd2048);
        chk("j_instr", instr, 32'h0010_006F);
        chk("j_addr", 32'(addr), 32'd3);
        chk("j_err", {31'b0, range_err}, 32'd0);

        // Range and alignment errors
        push_word(2'd0, 32'h0000_0013, 32'd2048);
        chk("ierr_instr", instr, 32'h8000_0013);
        chk("ierr_flag", {31'b0, range_err}, 32'd1);
        chk("ierr_cnt", 32'(err_cnt), 32'd1);
        chk("ierr_addr_wrap", 32'(addr), 32'd0);
        push_word(2'd2, 32'h0000_0063, 32'd3);
        chk("berr_instr", instr, 32'h0000_0163);
        chk("berr_flag", {31'b0, range_err}, 32'd1);
        chk("berr_cnt", 32'(err_cnt), 32'd2);

        // Range boundaries
        exp_cnt = 2;
        for (int k = 0; k < 10; k++) begin
            push_word(bnd_fmt[k], 32'h0000_0013, 32'(bnd_imm[k]));
            if (bnd_err[k]) exp_cnt++;
            chk("bnd_flag", {31'b0, range_err}, {31'b0, bnd_err[k]});
            chk("bnd_cnt", 32'(err_cnt), 32'(exp_cnt));
        end

        // Backpressure
        do_clear();
        out_ready = 1'b0;
        push_word(2'd0, 32'h0000_0013, 32'd1);
        push_word(2'd0, 32'h0000_0013, 32'd2);
        immsrc = 2'd0; base = 32'h0000_0013; imm = 32'd3; in_valid = 1'b1;
        #1;
        chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        chk("bp_stall_instr0", instr, 32'h0010_0013);
        chk("bp_stall_addr0", 32'(addr), 32'd0);
        chk("bp_stall_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        chk("bp_stall_instr1", instr, 32'h0010_0013);
        out_ready = 1'b1;
        #1;
        chk("bp_no_passthru", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("bp_out1_instr", instr, 32'h0020_0013);
        chk("bp_out1_addr", 32'(addr), 32'd1);
        chk("bp_ready_again", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_out2_instr", instr, 32'h0030_0013);
        chk("bp_out2_addr", 32'(addr), 32'd2);
        @(negedge clk);
        chk("bp_drained", {31'b0, out_valid}, 32'd0);

        // Address wrap
        do_clear();
        for (int k = 0; k < 5; k++) begin
            push_word(2'd0, 32'h0000_0013, 32'(k));
            exp_addr = k % 4;
            chk("wrap_addr", 32'(addr), 32'(exp_addr));
        end

        // Error counter saturation with back-to-back accepts
        do_clear();
        immsrc = 2'd0; base = 32'h0000_0013; imm = 32'd4096; in_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 300; k++) begin
            #1;
            if (in_ready) acc++;
            @(negedge clk);
            if (k == 253) chk("sat_cnt_254", 32'(err_cnt), 32'd254);
            if (k == 254) chk("sat_cnt_255", 32'(err_cnt), 32'd255);
        end
        in_valid = 1'b0;
        chk("sat_throughput", 32'(acc), 32'd300);
        chk("sat_cnt_hold", 32'(err_cnt), 32'd255);
        @(negedge clk);

        // Clear mid-stream
        do_clear();
        out_ready = 1'b0;
        push_word(2'd0, 32'h0000_0013, 32'd5);
        push_word(2'd0, 32'h0000_0013, 32'd4096);
        chk("clr_pre_valid", {31'b0, out_valid}, 32'd1);
        chk("clr_pre_cnt", 32'(err_cnt), 32'd1);
        imm = 32'd7; in_valid = 1'b1; clear = 1'b1; out_ready = 1'b1;
        #1;
        chk("clr_no_accept", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_valid", {31'b0, out_valid}, 32'd0);
        chk("clr_cnt", 32'(err_cnt), 32'd0);
        push_word(2'd0, 32'h0000_0013, 32'd9);
        chk("clr_next_addr", 32'(addr), 32'd0);
        chk("clr_next_instr", instr, 32'h0090_0013);

        // Reset mid-stream
        out_ready = 1'b0;
        push_word(2'd0, 32'h0000_0013, 32'd4096);
        chk("rstm_pre_cnt", 32'(err_cnt), 32'd1);
        chk("rstm_pre_valid", {31'b0, out_valid}, 32'd1);
        imm = 32'd7; in_valid = 1'b1; rst_n = 1'b0;
        #1;
        chk("rstm_no_accept", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        chk("rstm_valid", {31'b0, out_valid}, 32'd0);
        chk("rstm_instr", instr, 32'd0);
        chk("rstm_addr", 32'(addr), 32'd0);
        chk("rstm_err", {31'b0, range_err}, 32'd0);
        chk("rstm_cnt", 32'(err_cnt), 32'd0);
        chk("rstm_ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        push_word(2'd3, 32'h0000_006F, 32'd2048);
        chk("rstm_next_addr", 32'(addr), 32'd0);
        chk("rstm_next_instr", instr, 32'h0010_006F);

        // Round trip through the extender
        for (int k = 0; k < 10000; k++) begin
            f = 2'($urandom_range(0, 3));
            b = $urandom;
            case (f)
                2'd0, 2'd1: v = 32'(int'($urandom_range(0, 4095)) - 2048);
                2'd2:       v = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
                default:    v = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
            endcase
            push_word(f, b, v);
            chk("rt_imm", extend(instr, f), v);
            chk("rt_base_bits", instr & keep_mask(f), b & keep_mask(f));
            chk("rt_err", {31'b0, range_err}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
